// File: rtl/shift_rotate_seq_pkg.sv
// Shared ALU definitions: datapath sizing, shift/rotate op encodings and the
// sequencer state encoding for the iterative shift unit.
package shift_rotate_seq_pkg;

    localparam int ALU_WIDTH = 20;
    localparam int ALU_AMT_W = 5;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_ROR = 2'b01,
        OP_SHL = 2'b10,
        OP_SAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift_rotate_seq_shift_step.sv
// Single-position shift/rotate step. Purely combinational so it can serve both
// the iterative unit and the single-cycle ALU path.
module shift_step
    import shift_rotate_seq_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] word,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] next_word,
    output logic             out_bit
);

    // Move the word by one position; out_bit is whichever bit leaves the word.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next_word = word;
        out_bit   = 1'b0;
        case (op_e'(op))
            OP_ROL: begin
                next_word = {word[WIDTH-2:0], word[WIDTH-1]};
                out_bit   = word[WIDTH-1];
            end
            OP_ROR: begin
                next_word = {word[0], word[WIDTH-1:1]};
                out_bit   = word[0];
            end
            OP_SHL: begin
                next_word = {word[WIDTH-2:0], 1'b0};
                out_bit   = word[WIDTH-1];
            end
            OP_SAR: begin
                next_word = {word[WIDTH-1], word[WIDTH-1:1]};
                out_bit   = word[0];
            end
            default: begin
                next_word = word;
                out_bit   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_rotate_seq.sv
// Iterative shift/rotate unit: moves the operand one bit per clock for a
// variable count, with a start/busy/done handshake. Outputs are registered,
// so the done pulse appears one edge after the FSM reaches DONE.
module shift_rotate_seq
    import shift_rotate_seq_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int AMT_W = ALU_AMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    state_e             state_q;
    state_e             state_d;
    op_e                op_q;
    logic [WIDTH-1:0]   work_q;
    logic               work_c_q;
    logic [AMT_W-1:0]   count_q;
    logic [WIDTH-1:0]   step_word;
    logic               step_bit;
    logic               accept;
    logic               busy_d;
    logic               done_d;
    logic [WIDTH-1:0]   result_d;
    logic               carry_d;

    // A request is taken in IDLE, and also in DONE for back-to-back issue.
    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .word      (work_q),
        .op        (op_q),
        .next_word (step_word),
        .out_bit   (step_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: zero-amount requests skip RUN; RUN ends when the last step is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (amount != '0) ? ST_RUN : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (count_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: busy rises on acceptance; DONE publishes the working word and carry.
    always_comb begin
        busy_d   = busy;
        done_d   = 1'b0;
        result_d = result;
        carry_d  = carry;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
            end
            ST_DONE: begin
                done_d   = 1'b1;
                result_d = work_q;
                carry_d  = work_c_q;
                busy_d   = start;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
        end else begin
            busy   <= busy_d;
            done   <= done_d;
            result <= result_d;
            carry  <= carry_d;
        end
    end

    // Working datapath: load operand on acceptance, then one step per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= OP_ROL;
            work_q   <= '0;
            work_c_q <= 1'b0;
            count_q  <= '0;
        end else if (accept) begin
            op_q     <= op_e'(op);
            work_q   <= data_in;
            work_c_q <= 1'b0;
            count_q  <= amount;
        end else if (state_q == ST_RUN) begin
            work_q   <= step_word;
            work_c_q <= step_bit;
            count_q  <= count_q - AMT_W'(1);
        end
    end

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Directed bench for the iterative shift/rotate unit with hand-computed results.
module tb_shift_rotate_seq;
    import shift_rotate_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [19:0] data_in;
    logic [4:0]  amount;
    logic        busy;
    logic        done;
    logic [19:0] result;
    logic        carry;

    int checks = 0;
    int errors = 0;
    int cyc;
    bit saw_done;

    shift_rotate_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .amount  (amount),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry   (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a request; returns 1ns after the accepting edge with inputs scrambled.
    task automatic issue(input logic [1:0] o, input logic [19:0] d, input logic [4:0] a);
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        data_in = d;
        amount  = a;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 2'b11;
        data_in = 20'h5A5A5;
        amount  = 5'd7;
    endtask

    // Count edges until done is seen; cycles = -1 on timeout.
    task automatic wait_done(input int max_cycles, output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < max_cycles) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) found = 1'b1;
        end
        if (!found) cycles = -1;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        data_in = '0;
        amount  = '0;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", 32'(result), 32'h00000);
        check("rst_carry",  32'(carry),  32'd0);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("idle_no_done", 32'(saw_done), 32'd0);

        // ROL by 1
        issue(OP_ROL, 20'hAAAAA, 5'd1);
        wait_done(40, cyc);
        check("rol1_lat",    32'(cyc),    32'd2);
        check("rol1_result", 32'(result), 32'h55555);
        check("rol1_carry",  32'(carry),  32'd1);
        check("rol1_busy",   32'(busy),   32'd0);
        @(posedge clk);
        #1;
        check("rol1_pulse_width", 32'(done), 32'd0);
        check("rol1_hold",        32'(result), 32'h55555);

        // ROR by 3
        issue(OP_ROR, 20'h00001, 5'd3);
        wait_done(40, cyc);
        check("ror3_lat",    32'(cyc),    32'd4);
        check("ror3_result", 32'(result), 32'h20000);
        check("ror3_carry",  32'(carry),  32'd0);

        // ROL by 20 returns the operand; result holds during RUN
        issue(OP_ROL, 20'h12345, 5'd20);
        repeat (5) @(posedge clk);
        #1;
        check("rol20_busy_mid",   32'(busy),   32'd1);
        check("rol20_result_mid", 32'(result), 32'h20000);
        wait_done(40, cyc);
        check("rol20_lat",    32'(cyc),    32'd16);
        check("rol20_result", 32'(result), 32'h12345);
        check("rol20_carry",  32'(carry),  32'd1);

        // SAR by 5 with sign fill
        issue(OP_SAR, 20'h80010, 5'd5);
        wait_done(40, cyc);
        check("sar5_lat",    32'(cyc),    32'd6);
        check("sar5_result", 32'(result), 32'hFC000);
        check("sar5_carry",  32'(carry),  32'd1);

        // SHL by 25 saturates to zero
        issue(OP_SHL, 20'hFFFFF, 5'd25);
        wait_done(40, cyc);
        check("shl25_lat",    32'(cyc),    32'd26);
        check("shl25_result", 32'(result), 32'h00000);
        check("shl25_carry",  32'(carry),  32'd0);

        // amount 0
        issue(OP_ROR, 20'h0F0F0, 5'd0);
        wait_done(40, cyc);
        check("amt0_lat",    32'(cyc),    32'd1);
        check("amt0_result", 32'(result), 32'h0F0F0);
        check("amt0_carry",  32'(carry),  32'd0);

        // start during RUN is ignored
        issue(OP_ROR, 20'h0000F, 5'd4);
        @(negedge clk);
        start   = 1'b1;
        op      = OP_SHL;
        data_in = 20'h00000;
        amount  = 5'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        wait_done(40, cyc);
        check("ign_lat",    32'(cyc),    32'd4);
        check("ign_result", 32'(result), 32'hF0000);
        check("ign_carry",  32'(carry),  32'd1);
        @(posedge clk);
        #1;
        check("ign_no_second_done", 32'(done), 32'd0);

        // start in the DONE cycle is accepted back-to-back
        issue(OP_SHL, 20'hABCDE, 5'd0);
        start   = 1'b1;
        op      = OP_ROR;
        data_in = 20'h00003;
        amount  = 5'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_first_done",   32'(done),   32'd1);
        check("b2b_first_result", 32'(result), 32'hABCDE);
        check("b2b_busy",         32'(busy),   32'd1);
        wait_done(40, cyc);
        check("b2b_lat",    32'(cyc),    32'd3);
        check("b2b_result", 32'(result), 32'hC0000);
        check("b2b_carry",  32'(carry),  32'd1);

        // Reset mid-RUN
        issue(OP_ROL, 20'h12345, 5'd10);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_busy",   32'(busy),   32'd0);
        check("mrst_done",   32'(done),   32'd0);
        check("mrst_result", 32'(result), 32'h00000);
        check("mrst_carry",  32'(carry),  32'd0);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("mrst_quiet", 32'(saw_done), 32'd0);

        // SAR of a positive value by 19 and of a negative value by 31
        issue(OP_SAR, 20'h7FFFF, 5'd19);
        wait_done(60, cyc);
        check("sar19_lat",    32'(cyc),    32'd20);
        check("sar19_result", 32'(result), 32'h00000);
        check("sar19_carry",  32'(carry),  32'd1);

        issue(OP_SAR, 20'h80000, 5'd31);
        wait_done(60, cyc);
        check("sar31_lat",    32'(cyc),    32'd32);
        check("sar31_result", 32'(result), 32'hFFFFF);
        check("sar31_carry",  32'(carry),  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_rotate_seq.md
Name: shift_rotate_seq

Overview:
- Iterative multi-bit shift/rotate execution unit for the 20-bit ALU.
- The ALU's existing rotate path moves data by exactly one position, combinationally. This block moves data by an arbitrary amount (0-31) in either direction, one bit position per clock.
- Uses a start/busy/done handshake so the control sequencer can issue ROL, ROR, SHL and SAR with a variable count and collect the result and carry-out.

Parameters:
- WIDTH, 20, datapath width in bits.
- AMT_W, 5, width of the shift-amount field.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  in  1  request strobe; accepted only when busy=0.
- op  in  2  operation: 00 ROL, 01 ROR, 10 SHL (logical left, zero fill), 11 SAR (arithmetic right, sign fill).
- data_in  in  WIDTH  operand; sampled on accepted start.
- amount  in  AMT_W  number of single-bit steps; sampled on accepted start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; result and carry valid.
- result  out  WIDTH  operation result; held until the next accepted start.
- carry  out  1  last bit moved out of the word (the wrapped bit for rotates).

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst_n=0 at a clock edge), from any state including mid-operation:
  - state returns to IDLE;
  - busy=0, done=0, result=0, carry=0;
  - internal working register and count cleared.
- IDLE:
  - start=1 latches data_in into the working register, and latches op and amount.
  - Clears carry, sets busy=1.
  - Goes to RUN if amount!=0, else to DONE.
- RUN, each cycle:
  - Applies one step of op to the working register.
  - carry takes the bit shifted out: bit WIDTH-1 for ROL/SHL, bit 0 for ROR/SAR.
  - Decrements the count; when the count reaches 0 after a step, goes to DONE.
- Step definitions:
  - ROL: {w[WIDTH-2:0], w[WIDTH-1]}
  - ROR: {w[0], w[WIDTH-1:1]}
  - SHL: {w[WIDTH-2:0], 1'b0}
  - SAR: {w[WIDTH-1], w[WIDTH-1:1]}
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - result equals the working register.
  - Next state is IDLE, except that start=1 in this cycle is accepted exactly as in IDLE (back-to-back operation).
- Latency: start accepted at edge T gives done high in the cycle after edge T+amount+1. amount=0 takes 1 cycle to DONE, with result=data_in and carry=0.
- Amounts are not reduced or clamped. Iteration count equals amount, so:
  - rotates of 20 or more wrap naturally (rotate by 20 returns the operand);
  - SHL/SAR of 20 or more saturate to all-zero or all-sign.
- start while busy=1 (RUN): ignored, no state change. Inputs need not be held after acceptance.
- result and carry remain stable from DONE until the next accepted start.
- result does not change during RUN.
- The working register is internal; only DONE updates result.
- op is decoded only from its latched copy; changes on the op input during RUN have no effect.

Decomposition:
- Shared ALU package holds:
  - op encodings OP_ROL=2'b00, OP_ROR=2'b01, OP_SHL=2'b10, OP_SAR=2'b11;
  - the state enum;
  - WIDTH default 20.
- One sub-module: shift_step. It is purely combinational and takes the working word and op, returning the next word and the out-bit. It is reused by the single-cycle ALU path for 1-bit shifts.
- FSM, counter and output registers live in shift_rotate_seq.

Test Plan:
- Reset and idle: hold rst_n=0 for 2 cycles, then release. Expect busy=0, done=0, result=0x00000, carry=0, and no done pulse while start=0.
- ROL by 1: data_in=0xAAAAA, amount=1. Expect result=0x55555, carry=1, and done exactly 2 cycles after the accepting edge.
- ROR by 3: data_in=0x00001, amount=3. Expect result=0x20000, carry=0.
- ROL by 20: data_in=0x12345, amount=20. Expect result=0x12345, with done 21 cycles after acceptance.
- Shifts:
  - SAR by 5, data_in=0x80010: expect result=0xFC000, carry=1.
  - SHL by 25, data_in=0xFFFFF: expect result=0x00000, carry=0.
  - amount=0, data_in=0x0F0F0: expect done after 1 cycle with result=0x0F0F0.
- Handshake and reset:
  - Pulse start during RUN: expect it ignored and the original result returned.
  - Assert start in the DONE cycle: expect immediate acceptance.
  - Drop rst_n mid-RUN: expect IDLE next cycle, all outputs 0, and no done pulse.
